// File: rtl/commit_ctrl.sv
// Commit controller: sequences register, CSR and PC writes for one EXU instruction at a time.
// Define COMMIT_PERF_EN to build the 64-bit retired-instruction counter (instret).
module commit_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        exu_valid,
    output logic        commit_ready,
    input  logic [2:0]  csr_ctr,
    input  logic        rd_wen_in,
    input  logic [4:0]  rd,
    output logic        op_le,
    output logic        rf_wen,
    output logic [4:0]  rf_waddr,
    output logic        rf_wsel,
    output logic        csr_tmp_le,
    output logic        csr_wen,
    output logic [1:0]  csr_op,
    output logic        pc_wen,
    output logic [1:0]  pc_sel,
    output logic        commit_valid,
    input  logic        ifu_ready,
    output logic        halt,
    output logic [2:0]  halt_code,
    output logic [63:0] instret
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        COMMIT    = 3'd1,
        CSR_RD    = 3'd2,
        CSR_WR    = 3'd3,
        TRAP_SAVE = 3'd4,
        TRAP_PC   = 3'd5,
        DONE      = 3'd6,
        HALT      = 3'd7
    } state_t;

    localparam logic [2:0] CTR_PLAIN = 3'b000;
    localparam logic [2:0] CTR_ECALL = 3'b001;
    localparam logic [2:0] CTR_CSRRW = 3'b010;
    localparam logic [2:0] CTR_CSRRS = 3'b011;
    localparam logic [2:0] CTR_MRET  = 3'b100;

    state_t      state;
    state_t      next_state;
    logic [2:0]  ctr_q;
    logic [4:0]  rd_q;
    logic        rd_wen_q;
    logic        halt_q;
    logic        accept;

    logic        rf_wen_d;
    logic        rf_wsel_d;
    logic        csr_tmp_le_d;
    logic        csr_wen_d;
    logic [1:0]  csr_op_d;
    logic        pc_wen_d;
    logic [1:0]  pc_sel_d;
    logic        commit_valid_d;

    assign commit_ready = (state == IDLE) & ~rst;
    assign accept       = exu_valid & commit_ready;
    assign op_le        = accept;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            ctr_q    <= 3'b000;
            rd_q     <= 5'd0;
            rd_wen_q <= 1'b0;
            halt_q   <= 1'b0;
        end else begin
            state <= next_state;
            if (accept) begin
                ctr_q    <= csr_ctr;
                rd_q     <= rd;
                rd_wen_q <= rd_wen_in;
            end
            if (accept && next_state == HALT) begin
                halt_q <= 1'b1;
            end
        end
    end

    // Instruction class is decided once at accept; later states run from latched fields.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    case (csr_ctr)
                        CTR_PLAIN, CTR_MRET:  next_state = COMMIT;
                        CTR_CSRRW, CTR_CSRRS: next_state = CSR_RD;
                        CTR_ECALL:            next_state = TRAP_SAVE;
                        default:              next_state = HALT;
                    endcase
                end
            end
            COMMIT:    next_state = DONE;
            CSR_RD:    next_state = CSR_WR;
            CSR_WR:    next_state = DONE;
            TRAP_SAVE: next_state = TRAP_PC;
            TRAP_PC:   next_state = DONE;
            DONE: begin
                if (ifu_ready) begin
                    next_state = IDLE;
                end
            end
            HALT:      next_state = HALT;
            default:   next_state = IDLE;
        endcase
    end

    always_comb begin
        rf_wen_d       = 1'b0;
        rf_wsel_d      = 1'b0;
        csr_tmp_le_d   = 1'b0;
        csr_wen_d      = 1'b0;
        csr_op_d       = 2'b00;
        pc_wen_d       = 1'b0;
        pc_sel_d       = 2'b00;
        commit_valid_d = 1'b0;
        case (state)
            COMMIT: begin
                pc_wen_d = 1'b1;
                pc_sel_d = (ctr_q == CTR_MRET) ? 2'b10 : 2'b00;
                rf_wen_d = (ctr_q == CTR_PLAIN) && rd_wen_q && (rd_q != 5'd0);
            end
            CSR_RD: begin
                csr_tmp_le_d = 1'b1;
            end
            CSR_WR: begin
                csr_wen_d = 1'b1;
                csr_op_d  = (ctr_q == CTR_CSRRS) ? 2'b01 : 2'b00;
                rf_wen_d  = (rd_q != 5'd0);
                rf_wsel_d = 1'b1;
                pc_wen_d  = 1'b1;
                pc_sel_d  = 2'b00;
            end
            TRAP_SAVE: begin
                csr_wen_d = 1'b1;
                csr_op_d  = 2'b10;
            end
            TRAP_PC: begin
                pc_wen_d = 1'b1;
                pc_sel_d = 2'b01;
            end
            DONE: begin
                commit_valid_d = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Reset suppresses every strobe in the same cycle so an aborted instruction writes nothing.
    assign rf_wen       = rf_wen_d & ~rst;
    assign rf_waddr     = rf_wen ? rd_q : 5'd0;
    assign rf_wsel      = rf_wsel_d & ~rst;
    assign csr_tmp_le   = csr_tmp_le_d & ~rst;
    assign csr_wen      = csr_wen_d & ~rst;
    assign csr_op       = csr_op_d & {2{~rst}};
    assign pc_wen       = pc_wen_d & ~rst;
    assign pc_sel       = pc_sel_d & {2{~rst}};
    assign commit_valid = commit_valid_d;

    assign halt      = halt_q;
    assign halt_code = halt_q ? ctr_q : 3'b000;

`ifdef COMMIT_PERF_EN
    logic [63:0] instret_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            instret_q <= 64'd0;
        end else if (state == DONE && ifu_ready) begin
            instret_q <= instret_q + 64'd1;
        end
    end

    assign instret = instret_q;
`else
    assign instret = 64'd0;
`endif

endmodule

// File: tb/tb_commit_ctrl.sv
// Self-checking bench for commit_ctrl: directed scenarios then randomized traffic,
// every cycle compared against a transaction-level schedule model.
module tb_commit_ctrl;

    logic        clk;
    logic        rst;
    logic        exu_valid;
    logic        commit_ready;
    logic [2:0]  csr_ctr;
    logic        rd_wen_in;
    logic [4:0]  rd;
    logic        op_le;
    logic        rf_wen;
    logic [4:0]  rf_waddr;
    logic        rf_wsel;
    logic        csr_tmp_le;
    logic        csr_wen;
    logic [1:0]  csr_op;
    logic        pc_wen;
    logic [1:0]  pc_sel;
    logic        commit_valid;
    logic        ifu_ready;
    logic        halt;
    logic [2:0]  halt_code;
    logic [63:0] instret;

    commit_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .exu_valid    (exu_valid),
        .commit_ready (commit_ready),
        .csr_ctr      (csr_ctr),
        .rd_wen_in    (rd_wen_in),
        .rd           (rd),
        .op_le        (op_le),
        .rf_wen       (rf_wen),
        .rf_waddr     (rf_waddr),
        .rf_wsel      (rf_wsel),
        .csr_tmp_le   (csr_tmp_le),
        .csr_wen      (csr_wen),
        .csr_op       (csr_op),
        .pc_wen       (pc_wen),
        .pc_sel       (pc_sel),
        .commit_valid (commit_valid),
        .ifu_ready    (ifu_ready),
        .halt         (halt),
        .halt_code    (halt_code),
        .instret      (instret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One entry per post-accept cycle of an instruction: the write strobes expected in that cycle.
    typedef struct packed {
        logic       rf_wen;
        logic [4:0] rf_waddr;
        logic       rf_wsel;
        logic       csr_tmp_le;
        logic       csr_wen;
        logic [1:0] csr_op;
        logic       pc_wen;
        logic [1:0] pc_sel;
    } exp_t;

    exp_t        sched[$];
    logic        m_done;
    logic        m_halted;
    logic [2:0]  m_code;
    logic [63:0] m_instret;

    int n_tests;
    int n_fail;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        n_tests++;
        if (observed !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s at %0t: got %0h, expected %0h", tag, $time, observed, expected);
        end
    endtask

    task automatic checkCycle();
        exp_t        e;
        logic        exp_ready;
        logic        exp_cv;
        logic        exp_op_le;
        logic [63:0] exp_instret;
        e         = '0;
        exp_ready = 1'b0;
        exp_cv    = 1'b0;
        exp_op_le = 1'b0;
        if (!rst) begin
            if (m_halted) begin
                e = '0;
            end else if (sched.size() > 0) begin
                e = sched[0];
            end else if (m_done) begin
                exp_cv = 1'b1;
            end else begin
                exp_ready = 1'b1;
                exp_op_le = exu_valid;
            end
        end
        checkOutput("commit_ready", 64'(commit_ready), 64'(exp_ready));
        checkOutput("op_le",        64'(op_le),        64'(exp_op_le));
        checkOutput("rf_wen",       64'(rf_wen),       64'(e.rf_wen));
        checkOutput("rf_waddr",     64'(rf_waddr),     64'(e.rf_waddr));
        checkOutput("csr_tmp_le",   64'(csr_tmp_le),   64'(e.csr_tmp_le));
        checkOutput("csr_wen",      64'(csr_wen),      64'(e.csr_wen));
        checkOutput("pc_wen",       64'(pc_wen),       64'(e.pc_wen));
        if (e.rf_wen)  checkOutput("rf_wsel", 64'(rf_wsel), 64'(e.rf_wsel));
        if (e.csr_wen) checkOutput("csr_op",  64'(csr_op),  64'(e.csr_op));
        if (e.pc_wen)  checkOutput("pc_sel",  64'(pc_sel),  64'(e.pc_sel));
        if (!rst) begin
`ifdef COMMIT_PERF_EN
            exp_instret = m_instret;
`else
            exp_instret = 64'd0;
`endif
            checkOutput("commit_valid", 64'(commit_valid), 64'(exp_cv));
            checkOutput("halt",         64'(halt),         64'(m_halted));
            checkOutput("halt_code",    64'(halt_code),    64'(m_code));
            checkOutput("instret",      instret,           exp_instret);
        end
    endtask

    // Advance the model across the coming rising edge using the inputs of this cycle.
    task automatic updateModel();
        exp_t a;
        exp_t b;
        a = '0;
        b = '0;
        if (rst) begin
            sched.delete();
            m_done    = 1'b0;
            m_halted  = 1'b0;
            m_code    = 3'b000;
            m_instret = 64'd0;
        end else if (m_halted) begin
            m_halted = 1'b1;
        end else if (sched.size() > 0) begin
            void'(sched.pop_front());
            if (sched.size() == 0) m_done = 1'b1;
        end else if (m_done) begin
            if (ifu_ready) begin
                m_done    = 1'b0;
                m_instret = m_instret + 64'd1;
            end
        end else if (exu_valid) begin
            case (csr_ctr)
                3'b000: begin
                    a.pc_wen = 1'b1;
                    a.pc_sel = 2'b00;
                    if (rd_wen_in && rd != 5'd0) begin
                        a.rf_wen   = 1'b1;
                        a.rf_waddr = rd;
                        a.rf_wsel  = 1'b0;
                    end
                    sched.push_back(a);
                end
                3'b100: begin
                    a.pc_wen = 1'b1;
                    a.pc_sel = 2'b10;
                    sched.push_back(a);
                end
                3'b010, 3'b011: begin
                    a.csr_tmp_le = 1'b1;
                    b.csr_wen    = 1'b1;
                    b.csr_op     = (csr_ctr == 3'b011) ? 2'b01 : 2'b00;
                    b.pc_wen     = 1'b1;
                    b.pc_sel     = 2'b00;
                    if (rd != 5'd0) begin
                        b.rf_wen   = 1'b1;
                        b.rf_waddr = rd;
                        b.rf_wsel  = 1'b1;
                    end
                    sched.push_back(a);
                    sched.push_back(b);
                end
                3'b001: begin
                    a.csr_wen = 1'b1;
                    a.csr_op  = 2'b10;
                    b.pc_wen  = 1'b1;
                    b.pc_sel  = 2'b01;
                    sched.push_back(a);
                    sched.push_back(b);
                end
                default: begin
                    m_halted = 1'b1;
                    m_code   = csr_ctr;
                end
            endcase
        end
    endtask

    task automatic applyStimulus(input logic r, input logic ev, input logic [2:0] c,
                                 input logic rw, input logic [4:0] a, input logic ir);
        rst       = r;
        exu_valid = ev;
        csr_ctr   = c;
        rd_wen_in = rw;
        rd        = a;
        ifu_ready = ir;
        @(negedge clk);
        checkCycle();
        updateModel();
        @(posedge clk);
        #1;
    endtask

    logic       s_rst;
    logic       s_ev;
    logic [2:0] s_ctr;
    logic       s_rw;
    logic [4:0] s_rd;
    logic       s_ir;

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        m_done    = 1'b0;
        m_halted  = 1'b0;
        m_code    = 3'b000;
        m_instret = 64'd0;

        applyStimulus(1, 0, 3'b000, 0, 5'd0, 0);
        applyStimulus(1, 0, 3'b000, 0, 5'd0, 0);

        // Plain add to x5, then csrrw to x5, then ecall, each with IFU always ready.
        applyStimulus(0, 1, 3'b000, 1, 5'd5, 1);
        for (int i = 0; i < 2; i++) applyStimulus(0, 0, 3'b000, 0, 5'd0, 1);
        applyStimulus(0, 1, 3'b010, 1, 5'd5, 1);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 3'b000, 0, 5'd0, 1);
        applyStimulus(0, 1, 3'b001, 1, 5'd7, 1);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 3'b000, 0, 5'd0, 1);

        // rd=0 plain instruction with IFU stalled: commit_valid must hold, EXU must stay blocked.
        applyStimulus(0, 1, 3'b000, 1, 5'd0, 0);
        for (int i = 0; i < 5; i++) applyStimulus(0, 1, 3'b011, 1, 5'd9, 0);
        applyStimulus(0, 1, 3'b011, 1, 5'd9, 1);
        applyStimulus(0, 1, 3'b011, 1, 5'd9, 1);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 3'b000, 0, 5'd0, 1);

        // Reset while in CSR_RD must abort the csrrs before its CSR write.
        applyStimulus(0, 1, 3'b011, 1, 5'd4, 1);
        applyStimulus(1, 0, 3'b000, 0, 5'd0, 1);
        applyStimulus(0, 0, 3'b000, 0, 5'd0, 1);
        applyStimulus(0, 0, 3'b000, 0, 5'd0, 1);

        // Halt with code 111, ignore further EXU requests, leave only through reset.
        applyStimulus(0, 1, 3'b111, 0, 5'd1, 1);
        for (int i = 0; i < 4; i++) applyStimulus(0, 1, 3'b000, 1, 5'd3, 1);
        applyStimulus(1, 0, 3'b000, 0, 5'd0, 1);
        applyStimulus(0, 0, 3'b000, 0, 5'd0, 1);

        for (int i = 0; i < 4000; i++) begin
            s_rst = m_halted ? ($urandom_range(0, 99) < 15) : ($urandom_range(0, 99) < 2);
            s_ev  = ($urandom_range(0, 99) < 60);
            if ($urandom_range(0, 19) == 0) s_ctr = 3'($urandom_range(5, 7));
            else                            s_ctr = 3'($urandom_range(0, 4));
            s_rw  = 1'($urandom_range(0, 1));
            s_rd  = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            s_ir  = ($urandom_range(0, 99) < 50);
            applyStimulus(s_rst, s_ev, s_ctr, s_rw, s_rd, s_ir);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
